// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Sequences the irrigation actuator FSM. It starts a watering run when the
//   soil is dry, holds a one-cycle ARM so the zone switch settles before
//   watering rises, and bounds the run by a tick-based duration. Every run that
//   ends normally is followed by a rest period. A low tank latches a fault that
//   fault_clear releases.
//
//   Optional feature macro: IRRIGATION_ALTERNATE_EN
//     defined   - mode_select is ignored. The zone toggles after every run that
//                 ends in REST. The first run after reset uses the sprinkler.
//     undefined - the zone is latched from mode_select on IDLE->ARM.
//
//   Ports
//     clock, reset      rising-edge clock; asynchronous active-high reset
//     enable            scheduler enable
//     moisture          unsigned soil moisture sample
//     tank_low          water tank below minimum level
//     mode_select       zone request (0 sprinkler, 1 dripper)
//     fault_clear       leaves FAULT when tank_low is 0
//     watering          actuator watering command
//     splinker_switch   actuator sprinkler zone select
//     dripper_switch    actuator dripper zone select
//     busy              state != IDLE
//     fault             state == FAULT
//
//   state | meaning
//   IDLE  | waiting for a dry reading, or for tank_low
//   ARM   | one cycle with the zone switch on and watering off
//   WATER | watering; the run ends on tank_low, !enable, wet soil or timeout
//   REST  | enforced pause after a run
//   FAULT | tank empty, latched until fault_clear with tank_low = 0
module irrigation_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int SPLINK_TIME = 30,
  parameter int DRIP_TIME   = 120,
  parameter int REST_TIME   = 60,
  parameter int MOIST_W     = 8,
  parameter int DRY_THRESH  = 64,
  parameter int WET_THRESH  = 160
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [MOIST_W-1:0] moisture,
  input  logic               tank_low,
  input  logic               mode_select,
  input  logic               fault_clear,
  output logic               watering,
  output logic               splinker_switch,
  output logic               dripper_switch,
  output logic               busy,
  output logic               fault
);

  localparam int MAX_SD = (SPLINK_TIME > DRIP_TIME) ? SPLINK_TIME : DRIP_TIME;
  localparam int MAX_T  = (MAX_SD > REST_TIME) ? MAX_SD : REST_TIME;
  localparam int CW     = $clog2(MAX_T + 1);
  localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WATER,
    S_REST,
    S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic            zone, zone_nxt;   // 0 = sprinkler, 1 = dripper
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [CW-1:0]   dur, rest;
  logic            dry, wet;

  assign tick = (tcnt == TW'(TICK_DIV - 1));
  assign dry  = (moisture <  MOIST_W'(DRY_THRESH));
  assign wet  = (moisture >= MOIST_W'(WET_THRESH));

`ifdef IRRIGATION_ALTERNATE_EN
  logic unused_mode_select;
  assign unused_mode_select = mode_select;
`endif

  // The tick counter runs freely, so a run starts at any phase of the tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      zone  <= 1'b0;
    end else begin
      state <= state_nxt;
      zone  <= zone_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    zone_nxt  = zone;
    case (state)
      S_IDLE: begin
        if (tank_low) state_nxt = S_FAULT;
        else if (enable && dry) begin
          state_nxt = S_ARM;
`ifndef IRRIGATION_ALTERNATE_EN
          zone_nxt  = mode_select;
`endif
        end
      end
      S_ARM:   state_nxt = S_WATER;
      S_WATER: begin
        if (tank_low)                    state_nxt = S_FAULT;
        else if (!enable)                state_nxt = S_IDLE;
        else if (wet)                    state_nxt = S_REST;
        else if (tick && dur == CW'(1))  state_nxt = S_REST;
`ifdef IRRIGATION_ALTERNATE_EN
        // Only completed runs toggle the zone. Aborted runs keep it.
        if (state_nxt == S_REST) zone_nxt = ~zone;
`endif
      end
      S_REST:  if (tick && rest == CW'(1)) state_nxt = S_IDLE;
      S_FAULT: if (fault_clear && !tank_low) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dur  <= '0;
      rest <= '0;
    end else begin
      if (state == S_ARM)
        dur <= zone ? CW'(DRIP_TIME) : CW'(SPLINK_TIME);
      else if (state == S_WATER && tick && dur != '0)
        dur <= dur - CW'(1);

      if (state == S_WATER && state_nxt == S_REST)
        rest <= CW'(REST_TIME);
      else if (state == S_REST && tick && rest != '0)
        rest <= rest - CW'(1);
    end
  end

  // The outputs are decoded from the next state and registered, so each one
  // changes on the same edge as the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      watering        <= 1'b0;
      splinker_switch <= 1'b0;
      dripper_switch  <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      watering        <= (state_nxt == S_WATER);
      splinker_switch <= (state_nxt == S_ARM || state_nxt == S_WATER) && !zone_nxt;
      dripper_switch  <= (state_nxt == S_ARM || state_nxt == S_WATER) &&  zone_nxt;
      busy            <= (state_nxt != S_IDLE);
      fault           <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
Sequencer that drives the irrigation actuator FSM's watering / splinker_switch / dripper_switch inputs.
- Decides when to water from soil moisture and tank level; picks sprinkler or dripper zone.
- Bounds each watering run by a timed duration, then enforces a rest period.
- Latches a tank-empty fault that must be cleared explicitly.

Parameters:
TICK_DIV, 1000, clock cycles per time tick (>=1)
SPLINK_TIME, 30, sprinkler run length in ticks (>=1)
DRIP_TIME, 120, dripper run length in ticks (>=1)
REST_TIME, 60, post-run rest length in ticks (>=1)
MOIST_W, 8, moisture input width
DRY_THRESH, 64, start watering when moisture < DRY_THRESH
WET_THRESH, 160, stop early when moisture >= WET_THRESH (WET_THRESH > DRY_THRESH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  scheduler enable
moisture  input  MOIST_W  unsigned soil moisture sample
tank_low  input  1  water tank below minimum level
mode_select  input  1  zone request: 0 = sprinkler, 1 = dripper
fault_clear  input  1  clears FAULT when tank_low = 0
watering  output  1  to actuator FSM
splinker_switch  output  1  to actuator FSM
dripper_switch  output  1  to actuator FSM
busy  output  1  state != IDLE
fault  output  1  state == FAULT

Behaviour:
- One clock (clock); reset is asynchronous and active-high (reset).
- Reset state: IDLE, tick counter 0, all counters 0, zone latch = sprinkler. All outputs 0.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1, not cleared on state changes.
  - tick = 1 for one cycle when counter == TICK_DIV-1.
  - TICK_DIV = 1 gives tick every cycle.
- Counter widths: $clog2(max(SPLINK_TIME, DRIP_TIME, REST_TIME)+1); never decrements below 0.
- States: IDLE, ARM, WATER, REST, FAULT. All outputs are registered state decodes.
- IDLE: all outputs 0. Exit priority, highest first:
  - tank_low -> FAULT.
  - enable & moisture < DRY_THRESH -> ARM, latching zone = mode_select.
- ARM: exactly one cycle.
  - Zone switch = 1 (splinker_switch if zone 0, dripper_switch if zone 1); watering = 0.
  - Gives the actuator stable one-hot switches before watering rises.
  - Always -> WATER; load dur = SPLINK_TIME or DRIP_TIME per zone.
  - tank_low in ARM is acted on in WATER.
- WATER: watering = 1, zone switch = 1, other switch 0. Exit checked every cycle, priority order:
  - tank_low -> FAULT.
  - !enable -> IDLE (no rest).
  - moisture >= WET_THRESH -> REST.
  - tick & dur == 1 -> REST.
  - Otherwise: tick decrements dur.
  - With TICK_DIV = 1, WATER lasts exactly dur cycles.
- REST: all actuator outputs 0.
  - Load rest = REST_TIME on entry; decrement on tick; tick & rest == 1 -> IDLE.
  - tank_low and enable ignored in REST; IDLE re-evaluates them.
- FAULT: all actuator outputs 0, fault = 1.
  - -> IDLE only when fault_clear & !tank_low in the same cycle.
  - fault_clear while tank_low = 1 is ignored.
- Mid-run input changes: mode_select changes after ARM entry are ignored until the next IDLE->ARM.
- Invariant: splinker_switch & dripper_switch never both 1.
- Invariant: watering = 1 only in WATER.
- Reset asserted mid-run: all outputs drop to 0 asynchronously; FSM returns to IDLE.

Optional Feature:
IRRIGATION_ALTERNATE_EN
- Defined:
  - mode_select is ignored.
  - Zone latch toggles after each run that leaves WATER for REST (timeout or wet).
  - Runs aborted to IDLE or FAULT do not toggle.
  - First run after reset uses sprinkler.
- Undefined: zone taken from mode_select at IDLE->ARM; no toggling logic is built.

Test Plan:
All scenarios use TICK_DIV=1, SPLINK_TIME=4, DRIP_TIME=6, REST_TIME=3, MOIST_W=4, DRY_THRESH=4, WET_THRESH=10, unless stated.
- Sprinkler run: enable=1, moisture=2, mode_select=0, tank_low=0 -> ARM 1 cycle (splinker_switch=1, watering=0), WATER 4 cycles (watering=1), REST 3 cycles (outputs 0), then IDLE and restart if still dry.
- Dripper with early wet: mode_select=1, moisture=2; raise moisture to 12 on WATER cycle 3 -> REST next cycle; dripper_switch=1 only during ARM/WATER; splinker_switch stays 0.
- Tank fault: tank_low=1 on WATER cycle 2 -> FAULT next cycle, watering=0, fault=1; fault_clear with tank_low=1 -> stays FAULT; tank_low=0 + fault_clear -> IDLE.
- Disable and reset mid-run: enable=0 during WATER -> IDLE next cycle, no REST; separately, reset during WATER -> all outputs 0 immediately, busy=0.
- Tick scaling: TICK_DIV=5, SPLINK_TIME=2 -> WATER duration between 6 and 10 cycles depending on tick phase; dur decrements only on tick.
- IRRIGATION_ALTERNATE_EN defined, moisture held 2 -> zones sprinkler, dripper, sprinkler on consecutive runs regardless of mode_select.
